// File: rtl/seg7_scan_capture_if.sv
// Bus between a multiplexed seven-segment display and the scan capture monitor.
// The display side (master) drives anode/segment; the monitor (slave) returns the decoded frame.
interface seg7_scan_capture_if;
  logic [3:0]  an;
  logic [6:0]  segment;
  logic [15:0] value;
  logic        frame_valid;
  logic        bad_pattern;
  logic        stale;

  modport master (
    output an, segment,
    input  value, frame_valid, bad_pattern, stale
  );

  modport slave (
    input  an, segment,
    output value, frame_valid, bad_pattern, stale
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Display monitor: synchronizes the active-low anode/segment buses, waits for each digit
// to settle, decodes its glyph and assembles a 16-bit value once all four digits are seen.
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_capture_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  // Returns {legal, nibble}; blank and every non-hex pattern are illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode_glyph = 5'h10;
      7'b1111001: decode_glyph = 5'h11;
      7'b0100100: decode_glyph = 5'h12;
      7'b0110000: decode_glyph = 5'h13;
      7'b0011001: decode_glyph = 5'h14;
      7'b0010010: decode_glyph = 5'h15;
      7'b0000010: decode_glyph = 5'h16;
      7'b1111000: decode_glyph = 5'h17;
      7'b0000000: decode_glyph = 5'h18;
      7'b0010000: decode_glyph = 5'h19;
      7'b0001000: decode_glyph = 5'h1A;
      7'b0000011: decode_glyph = 5'h1B;
      7'b1000110: decode_glyph = 5'h1C;
      7'b0100001: decode_glyph = 5'h1D;
      7'b0000110: decode_glyph = 5'h1E;
      7'b0001110: decode_glyph = 5'h1F;
      default:    decode_glyph = 5'h00;
    endcase
  endfunction

  function automatic logic legal_anode(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal_anode = 1'b1;
      default:                            legal_anode = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] a);
    case (a)
      4'b1110: anode_index = 2'd0;
      4'b1101: anode_index = 2'd1;
      4'b1011: anode_index = 2'd2;
      4'b0111: anode_index = 2'd3;
      default: anode_index = 2'd0;
    endcase
  endfunction

  logic [3:0]    an_meta_r, an_sync_r, rec_an_r;
  logic [6:0]    seg_meta_r, seg_sync_r, rec_seg_r;
  state_t        state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s, cnt_inc_s;
  logic          load_s, sample_s, changed_s, legal_an_s;
  logic [TW-1:0] tmo_r;
  logic [3:0]    seen_r, seen_next_s;
  logic [15:0]   staging_r, value_r;
  logic          frame_valid_r, bad_pattern_r, stale_r;
  logic [4:0]    glyph_s;
  logic [1:0]    digit_s;
  logic          good_s, complete_s, timeout_s;

  assign legal_an_s = legal_anode(an_sync_r);
  assign changed_s  = (an_sync_r != rec_an_r) || (seg_sync_r != rec_seg_r);
  assign cnt_inc_s  = (cnt_r == SETTLE_MAX) ? cnt_r : cnt_r + CW'(1'b1);
  assign glyph_s    = decode_glyph(rec_seg_r);
  assign digit_s    = anode_index(rec_an_r);
  assign good_s     = sample_s & glyph_s[4];
  assign complete_s = (seen_r == 4'hF);
  assign timeout_s  = !good_s && (tmo_r == TMO_LAST);

  assign bus.value       = value_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.bad_pattern = bad_pattern_r;
  assign bus.stale       = stale_r;

  // Two-flop synchronizers; idle value is "all digits off, all segments dark".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_meta_r  <= 4'hF;
      an_sync_r  <= 4'hF;
      seg_meta_r <= 7'h7F;
      seg_sync_r <= 7'h7F;
    end else begin
      an_meta_r  <= bus.an;
      an_sync_r  <= an_meta_r;
      seg_meta_r <= bus.segment;
      seg_sync_r <= seg_meta_r;
    end
  end

  // FSM state, settle counter and the recorded anode/segment pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      rec_an_r  <= 4'hF;
      rec_seg_r <= 7'h7F;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (load_s) begin
        rec_an_r  <= an_sync_r;
        rec_seg_r <= seg_sync_r;
      end
    end
  end

  // Next state: HOLD blocks a second sample until the bus moves on.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    load_s       = 1'b0;
    sample_s     = 1'b0;
    case (state_r)
      IDLE, HOLD: begin
        if ((state_r == IDLE || changed_s) && legal_an_s) begin
          state_next_s = SETTLE;
          cnt_next_s   = CW'(1'b1);
          load_s       = 1'b1;
        end else if (changed_s) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else begin
          state_next_s = state_r;
        end
      end
      SETTLE: begin
        if (changed_s && legal_an_s) begin
          cnt_next_s = CW'(1'b1);
          load_s     = 1'b1;
        end else if (changed_s) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else if (cnt_inc_s >= SETTLE_MAX) begin
          cnt_next_s   = cnt_inc_s;
          sample_s     = 1'b1;
          state_next_s = HOLD;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Seen mask: completion and timeout restart the frame, a good sample marks its digit.
  always_comb begin
    seen_next_s = seen_r;
    if (complete_s || timeout_s) begin
      seen_next_s = 4'h0;
    end else begin
      seen_next_s = seen_r;
    end
    if (good_s) begin
      seen_next_s = seen_next_s | (4'b0001 << digit_s);
    end else begin
      seen_next_s = seen_next_s;
    end
  end

  // Staging, frame output, timeout counter and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_r        <= 4'h0;
      staging_r     <= 16'h0000;
      value_r       <= 16'h0000;
      frame_valid_r <= 1'b0;
      bad_pattern_r <= 1'b0;
      stale_r       <= 1'b0;
      tmo_r         <= '0;
    end else begin
      seen_r        <= seen_next_s;
      frame_valid_r <= complete_s;
      bad_pattern_r <= sample_s & ~glyph_s[4];
      if (good_s) begin
        staging_r[{digit_s, 2'b00} +: 4] <= glyph_s[3:0];
      end
      if (complete_s) begin
        value_r <= staging_r;
      end
      if (good_s || timeout_s) begin
        tmo_r <= '0;
      end else begin
        tmo_r <= tmo_r + TW'(1'b1);
      end
      if (complete_s) begin
        stale_r <= 1'b0;
      end else if (timeout_s) begin
        stale_r <= 1'b1;
      end
    end
  end
endmodule
